dec_unbinder_pack: RTL

//  Decoder-side inverse of the encoder binder packs. Captures one bound hypervector,

---
 rtl/hdc_pkg.sv | 24 ++
 rtl/dec_overlap_unit.sv | 18 +
 rtl/dec_unbinder_pack.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hdc_pkg.sv
// Shared hypervector definitions: dimension, per-feature binding shifts,
// overlap count type and the decoder state encoding.
package hdc_pkg;

  localparam int HV_DIM     = 256;
  localparam int NUM_SHIFTS = 12;

  // Raw encoder rotations, indexed by global feature; values may exceed HV_DIM
  localparam int SHIFTS [NUM_SHIFTS] = '{0, 20, 296, 60, 80, 356, 120, 140, 160, 180, 7, 255};

  typedef logic [$clog2(HV_DIM+1)-1:0] overlap_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNBIND = 2'd1,
    ST_SCAN   = 2'd2,
    ST_EMIT   = 2'd3
  } dec_state_t;

  function automatic int shift_of(input int idx);
    return SHIFTS[idx] % HV_DIM;
  endfunction

endpackage

// File: rtl/dec_overlap_unit.sv
// Combinational overlap score: population count of the bitwise AND of two
// hypervectors.
module dec_overlap_unit
  import hdc_pkg::*;
(
  input  logic [HV_DIM-1:0] i_a,
  input  logic [HV_DIM-1:0] i_b,
  output overlap_t          o_ovl
);

  always_comb begin
    o_ovl = '0;
    for (int i = 0; i < HV_DIM; i++) begin
      o_ovl = o_ovl + overlap_t'(i_a[i] & i_b[i]);
    end
  end

endmodule

// File: rtl/dec_unbinder_pack.sv
// Pack unbinder: captures a bound hypervector, undoes each feature's rotation
// and streams out the best-matching level per feature.
module dec_unbinder_pack
  import hdc_pkg::*;
#(
  parameter  int PACK_BASE  = 0,
  parameter  int PACK_SIZE  = 10,
  parameter  int NUM_LEVELS = 16,
  localparam int FEAT_W     = (PACK_SIZE  > 1) ? $clog2(PACK_SIZE)  : 1,
  localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
)(
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                start_decoding,
  input  logic [HV_DIM-1:0]                   bound_hv,
  input  logic [NUM_LEVELS-1:0][HV_DIM-1:0]   level_hv,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [FEAT_W-1:0]                   out_feature,
  output logic [LVL_W-1:0]                    out_level,
  output overlap_t                            out_overlap,
  output logic                                done
);

  localparam int ROT_W = $clog2(HV_DIM);

  dec_state_t           r_state;
  logic [HV_DIM-1:0]    r_bound;
  logic [HV_DIM-1:0]    r_unshift;
  logic [FEAT_W-1:0]    r_feat;
  logic [LVL_W-1:0]     r_lvl;
  logic [LVL_W-1:0]     r_best_lvl;
  overlap_t             r_best_ovl;
  logic                 r_busy;
  logic                 r_out_valid;
  logic [FEAT_W-1:0]    r_out_feature;
  logic [LVL_W-1:0]     r_out_level;
  overlap_t             r_out_overlap;
  logic                 r_done;

  logic [ROT_W-1:0]     w_rot_amt;
  logic [2*HV_DIM-1:0]  w_dbl;
  logic [HV_DIM-1:0]    w_unshift;
  overlap_t             w_ovl;
  logic                 w_better;
  logic                 w_last_lvl;
  logic                 w_last_feat;

  // Encoder rotated left by S, so the inverse is a right rotation by S.
  assign w_rot_amt   = ROT_W'(shift_of(PACK_BASE + int'(r_feat)));
  assign w_dbl       = {r_bound, r_bound};
  assign w_unshift   = HV_DIM'(w_dbl >> w_rot_amt);

  assign w_better    = (w_ovl > r_best_ovl);
  assign w_last_lvl  = (r_lvl  == LVL_W'(NUM_LEVELS - 1));
  assign w_last_feat = (r_feat == FEAT_W'(PACK_SIZE - 1));

  dec_overlap_unit u_overlap (
    .i_a   (r_unshift),
    .i_b   (level_hv[r_lvl]),
    .o_ovl (w_ovl)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= ST_IDLE;
      r_bound       <= '0;
      r_unshift     <= '0;
      r_feat        <= '0;
      r_lvl         <= '0;
      r_best_lvl    <= '0;
      r_best_ovl    <= '0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_feature <= '0;
      r_out_level   <= '0;
      r_out_overlap <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_decoding) begin
            r_bound <= bound_hv;
            r_feat  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_UNBIND;
          end
        end
        ST_UNBIND: begin
          r_unshift  <= w_unshift;
          r_lvl      <= '0;
          r_best_ovl <= '0;
          r_best_lvl <= '0;
          r_state    <= ST_SCAN;
        end
        ST_SCAN: begin
          // Strict compare keeps the lowest level index on ties
          if (w_better) begin
            r_best_ovl <= w_ovl;
            r_best_lvl <= r_lvl;
          end
          if (w_last_lvl) begin
            r_out_feature <= r_feat;
            r_out_level   <= w_better ? r_lvl : r_best_lvl;
            r_out_overlap <= w_better ? w_ovl : r_best_ovl;
            r_out_valid   <= 1'b1;
            r_state       <= ST_EMIT;
          end else begin
            r_lvl <= r_lvl + LVL_W'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_feat) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_feat  <= r_feat + FEAT_W'(1);
              r_state <= ST_UNBIND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign out_feature = r_out_feature;
  assign out_level   = r_out_level;
  assign out_overlap = r_out_overlap;
  assign done        = r_done;

endmodule
